// File: rtl/alu_wide_seq.sv
// Multi-pass sequencer around the 4-bit alu_flags datapath.
// Commands of WIDTH bits are walked through the ALU one nibble per cycle,
// LSB first, chaining the carry between passes. The wide result and the
// combined {V,N,Z,C} flags are held until the consumer takes them.
//
// state | meaning
// IDLE  | ready for a command, ALU inputs parked at zero
// RUN   | one nibble pass per cycle, idx_q selects the nibble
// DONE  | result and flags valid, waiting for res_ready
module alu_wide_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_h,
    input  logic             cmd_cin,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_h,
    output logic             alu_cin,
    input  logic [3:0]       alu_f,
    input  logic [3:0]       alu_flags,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_f,
    output logic [3:0]       res_flags,
    output logic [7:0]       ovf_count
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [2:0]        h_q, h_d;
    logic              cin_q, cin_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              carry_q, carry_d;
    logic [3:0]        flags_q, flags_d;
    logic [7:0]        ovf_q, ovf_d;
    logic              v_last, c_last;

    // State and datapath registers; reset clears everything, including mid-pass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            h_q     <= '0;
            cin_q   <= 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            flags_q <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            h_q     <= h_d;
            cin_q   <= cin_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            flags_q <= flags_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic: accept, per-nibble capture, flag assembly, result handshake.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        h_d     = h_q;
        cin_d   = cin_q;
        idx_d   = idx_q;
        res_d   = res_q;
        carry_d = carry_q;
        flags_d = flags_q;
        ovf_d   = ovf_q;
        v_last  = 1'b0;
        c_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    h_d     = cmd_h;
                    cin_d   = cmd_cin;
                    idx_d   = '0;
                    res_d   = '0;
                    carry_d = 1'b0;
                    flags_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NIB; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        res_d[4*i +: 4] = alu_f;
                    end
                end
                carry_d = alu_flags[0];
                if (idx_q == LAST) begin
                    // Logical ops never report carry or overflow.
                    v_last  = h_q[2] ? 1'b0 : alu_flags[3];
                    c_last  = h_q[2] ? 1'b0 : alu_flags[0];
                    flags_d = {v_last, res_d[WIDTH-1], (res_d == '0), c_last};
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                    if (flags_q[3] && (ovf_q != 8'hFF)) begin
                        ovf_d = ovf_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ALU drive: selected nibble and chained carry while running, zero otherwise.
    always_comb begin
        alu_a   = 4'h0;
        alu_b   = 4'h0;
        alu_h   = 3'b000;
        alu_cin = 1'b0;
        if (state_q == RUN) begin
            for (int i = 0; i < NIB; i++) begin
                if (idx_q == IDXW'(i)) begin
                    alu_a = a_q[4*i +: 4];
                    alu_b = b_q[4*i +: 4];
                end
            end
            alu_h = h_q;
            if (idx_q == '0) begin
                alu_cin = cin_q;
            end else begin
                alu_cin = h_q[2] ? 1'b0 : carry_q;
            end
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign res_valid = (state_q == DONE);
    assign res_f     = res_q;
    assign res_flags = flags_q;
    assign ovf_count = ovf_q;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq: behavioural 4-bit ALU on the alu_* side, a wide
// reference model and a scoreboard queue on the command/result side.
module tb_alu_wide_seq;

    localparam int W   = 8;
    localparam int NIB = W / 4;

    logic          clk;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_a;
    logic [W-1:0]  cmd_b;
    logic [2:0]    cmd_h;
    logic          cmd_cin;
    logic [3:0]    alu_a;
    logic [3:0]    alu_b;
    logic [2:0]    alu_h;
    logic          alu_cin;
    logic [3:0]    alu_f;
    logic [3:0]    alu_flags;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_f;
    logic [3:0]    res_flags;
    logic [7:0]    ovf_count;

    int n_checks;
    int n_fail;
    int ovf_model;

    typedef struct packed {
        logic [W-1:0] f;
        logic [3:0]   flags;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   h;
        logic         cin;
        logic [W-1:0] f;
        logic [3:0]   flags;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];

    alu_wide_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_h     (cmd_h),
        .cmd_cin   (cmd_cin),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_h     (alu_h),
        .alu_cin   (alu_cin),
        .alu_f     (alu_f),
        .alu_flags (alu_flags),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_f     (res_f),
        .res_flags (res_flags),
        .ovf_count (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit alu_flags stand-in.
    logic [3:0] m_bop;
    logic [4:0] m_sum;
    always_comb begin
        m_bop     = 4'h0;
        m_sum     = 5'h0;
        alu_f     = 4'h0;
        alu_flags = 4'h0;
        case (alu_h[1:0])
            2'b00:   m_bop = 4'h0;
            2'b01:   m_bop = alu_b;
            2'b10:   m_bop = ~alu_b;
            default: m_bop = 4'hF;
        endcase
        if (!alu_h[2]) begin
            m_sum = {1'b0, alu_a} + {1'b0, m_bop} + {4'h0, alu_cin};
            alu_f = m_sum[3:0];
            alu_flags[0] = m_sum[4];
            alu_flags[3] = (alu_a[3] == m_bop[3]) && (alu_f[3] != alu_a[3]);
        end else begin
            case (alu_h[1:0])
                2'b00:   alu_f = alu_a & alu_b;
                2'b01:   alu_f = alu_a | alu_b;
                2'b10:   alu_f = alu_a ^ alu_b;
                default: alu_f = ~alu_a;
            endcase
        end
        alu_flags[2] = alu_f[3];
        alu_flags[1] = (alu_f == 4'h0);
    end

    function automatic logic [W-1:0] bop_of(input logic [W-1:0] b, input logic [2:0] h);
        case (h[1:0])
            2'b00:   return '0;
            2'b01:   return b;
            2'b10:   return ~b;
            default: return '1;
        endcase
    endfunction

    // Whole-word reference result.
    function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [2:0] h, input logic cin);
        exp_t         e;
        logic [W-1:0] bo;
        logic [W:0]   s;
        logic         v;
        logic         c;
        bo = bop_of(b, h);
        v  = 1'b0;
        c  = 1'b0;
        if (!h[2]) begin
            s   = {1'b0, a} + {1'b0, bo} + {{W{1'b0}}, cin};
            e.f = s[W-1:0];
            c   = s[W];
            v   = (a[W-1] == bo[W-1]) && (e.f[W-1] != a[W-1]);
        end else begin
            case (h[1:0])
                2'b00:   e.f = a & b;
                2'b01:   e.f = a | b;
                2'b10:   e.f = a ^ b;
                default: e.f = ~a;
            endcase
        end
        e.flags = {v, e.f[W-1], (e.f == '0), c};
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Entered and left on a falling edge. Drives a command and waits for the accepting edge.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] h, input logic cin, input exp_t e);
        int n;
        cmd_a     = a;
        cmd_b     = b;
        cmd_h     = h;
        cmd_cin   = cin;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        sb.push_back(e);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    // Checks every nibble pass and that res_valid rises exactly NIB edges after accept.
    task automatic run_passes(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [2:0] h, input logic cin);
        logic [W-1:0] bo;
        logic [W-1:0] m;
        logic [W-1:0] t;
        logic [W:0]   s;
        logic         exp_cin;
        bo = bop_of(b, h);
        for (int k = 0; k < NIB; k++) begin
            m = (k == 0) ? '0 : W'((1 << (4 * k)) - 1);
            s = {1'b0, a & m} + {1'b0, bo & m} + {{W{1'b0}}, cin};
            exp_cin = (k == 0) ? cin : (h[2] ? 1'b0 : s[4*k]);
            t = a >> (4 * k);
            chk("pass_res_valid", {31'd0, res_valid}, 32'd0);
            chk("pass_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("pass_alu_a", {28'd0, alu_a}, {28'd0, t[3:0]});
            chk("pass_alu_h", {29'd0, alu_h}, {29'd0, h});
            chk("pass_alu_cin", {31'd0, alu_cin}, {31'd0, exp_cin});
            @(negedge clk);
        end
        chk("latency_res_valid", {31'd0, res_valid}, 32'd1);
    endtask

    // Holds res_ready low for 'hold' cycles, then completes the result handshake.
    task automatic deliver(input int hold);
        exp_t e;
        chk("sb_nonempty", {31'd0, (sb.size() == 0)}, 32'd0);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        for (int i = 0; i < hold; i++) begin
            chk("hold_res_f", {24'd0, res_f}, {24'd0, e.f});
            chk("hold_res_flags", {28'd0, res_flags}, {28'd0, e.flags});
            chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        chk("res_valid", {31'd0, res_valid}, 32'd1);
        chk("res_f", {24'd0, res_f}, {24'd0, e.f});
        chk("res_flags", {28'd0, res_flags}, {28'd0, e.flags});
        res_ready = 1'b1;
        @(posedge clk);
        if (res_valid && e.flags[3] && ovf_model < 255) ovf_model++;
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk("ovf_count", {24'd0, ovf_count}, ovf_model);
        chk("post_res_valid", {31'd0, res_valid}, 32'd0);
        chk("post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("idle_alu_drive", {20'd0, alu_a, alu_b, alu_h, alu_cin}, 32'd0);
    endtask

    task automatic run_cmd(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] h, input logic cin, input exp_t e);
        accept(a, b, h, cin, e);
        run_passes(a, b, h, cin);
        deliver(0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [2:0]   rh;
        logic         rc;

        n_checks  = 0;
        n_fail    = 0;
        ovf_model = 0;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_h     = '0;
        cmd_cin   = 1'b0;
        res_ready = 1'b0;
        reset_n   = 1'b0;

        vecs[0] = '{8'h0F, 8'h01, 3'b001, 1'b0, 8'h10, 4'b0000};
        vecs[1] = '{8'h7F, 8'h01, 3'b001, 1'b0, 8'h80, 4'b1100};
        vecs[2] = '{8'h00, 8'h01, 3'b010, 1'b1, 8'hFF, 4'b0100};
        vecs[3] = '{8'hFF, 8'h01, 3'b001, 1'b0, 8'h00, 4'b0011};
        vecs[4] = '{8'h3C, 8'h0F, 3'b100, 1'b0, 8'h0C, 4'b0000};
        vecs[5] = '{8'hFF, 8'h00, 3'b111, 1'b0, 8'h00, 4'b0010};
        vecs[6] = '{8'h5A, 8'hF0, 3'b101, 1'b0, 8'hFA, 4'b0100};
        vecs[7] = '{8'h5A, 8'hFF, 3'b110, 1'b1, 8'hA5, 4'b0100};
        vecs[8] = '{8'h80, 8'h00, 3'b011, 1'b0, 8'h7F, 4'b1001};
        vecs[9] = '{8'h10, 8'h00, 3'b000, 1'b1, 8'h11, 4'b0000};

        repeat (3) @(negedge clk);
        chk("reset_res_f", {24'd0, res_f}, 32'd0);
        chk("reset_res_flags", {28'd0, res_flags}, 32'd0);
        chk("reset_res_valid", {31'd0, res_valid}, 32'd0);
        chk("reset_ovf", {24'd0, ovf_count}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            e.f     = vecs[i].f;
            e.flags = vecs[i].flags;
            run_cmd(vecs[i].a, vecs[i].b, vecs[i].h, vecs[i].cin, e);
        end

        // Random commands against the whole-word model.
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rh = 3'($urandom_range(0, 7));
            rc = 1'($urandom_range(0, 1));
            run_cmd(ra, rb, rh, rc, ref_model(ra, rb, rh, rc));
        end

        // Back-pressure: result held with a second command waiting.
        accept(8'h7F, 8'h01, 3'b001, 1'b0, 8'h80 << 4 | 12'h0C);
        run_passes(8'h7F, 8'h01, 3'b001, 1'b0);
        cmd_a     = 8'h22;
        cmd_b     = 8'h11;
        cmd_h     = 3'b010;
        cmd_cin   = 1'b1;
        cmd_valid = 1'b1;
        deliver(5);
        chk("bp_not_accepted_early", {31'd0, res_valid}, 32'd0);
        accept(8'h22, 8'h11, 3'b010, 1'b1, {8'h11, 4'b0001});
        run_passes(8'h22, 8'h11, 3'b010, 1'b1);
        deliver(0);

        // Reset during the first pass.
        accept(8'h7F, 8'h01, 3'b001, 1'b0, ref_model(8'h7F, 8'h01, 3'b001, 1'b0));
        reset_n = 1'b0;
        #1;
        chk("midrun_res_valid", {31'd0, res_valid}, 32'd0);
        chk("midrun_res_f", {24'd0, res_f}, 32'd0);
        chk("midrun_res_flags", {28'd0, res_flags}, 32'd0);
        chk("midrun_ovf", {24'd0, ovf_count}, 32'd0);
        chk("midrun_alu_drive", {20'd0, alu_a, alu_b, alu_h, alu_cin}, 32'd0);
        sb.delete();
        ovf_model = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrun_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        run_cmd(8'h0F, 8'h01, 3'b001, 1'b0, {8'h10, 4'b0000});

        // Overflow counter saturation.
        for (int i = 0; i < 256; i++) begin
            run_cmd(8'h7F, 8'h01, 3'b001, 1'b0, {8'h80, 4'b1100});
        end
        chk("ovf_saturated", {24'd0, ovf_count}, 32'hFF);
        run_cmd(8'h40, 8'h40, 3'b001, 1'b0, {8'h80, 4'b1100});
        chk("ovf_stays_saturated", {24'd0, ovf_count}, 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_wide_seq.md
Name: alu_wide_seq

Overview:
- Multi-pass sequencer wrapped around the 4-bit alu_flags datapath.
- Accepts WIDTH-bit commands over a valid/ready handshake.
- Drives the ALU one nibble per cycle, LSB first, chaining carry between nibbles, then assembles the wide result and the combined {V,N,Z,C} flags.
- Sits directly upstream of alu_flags (drives its A/B/H/Cin) and consumes its F/ALUflags.

Parameters:
- WIDTH, 8, operand/result width. Must be a multiple of 4 and >= 8. NIB = WIDTH/4 passes.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- cmd_h  in  3  ALU opcode, same encoding as alu_flags
- cmd_cin  in  1  carry-in for nibble 0
- alu_a  out  4  to alu_flags A
- alu_b  out  4  to alu_flags B
- alu_h  out  3  to alu_flags H
- alu_cin  out  1  to alu_flags Cin
- alu_f  in  4  from alu_flags F
- alu_flags  in  4  from alu_flags, {V,N,Z,C}
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_f  out  WIDTH  assembled result
- res_flags  out  4  {V,N,Z,C}
- ovf_count  out  8  saturating count of delivered results with V=1

Behaviour:
- Opcodes: 000 A+Cin; 001 A+B+Cin; 010 A+~B+Cin; 011 A+4'hF+Cin; 100 AND; 101 OR; 110 XOR; 111 ~A.
- Arithmetic means h[2]=0; logical means h[2]=1.
- States:
  - IDLE: cmd_ready=1, res_valid=0.
  - RUN: nibble counter idx 0..NIB-1, cmd_ready=0.
  - DONE: res_valid=1, cmd_ready=0.
- IDLE->RUN on cmd_valid&&cmd_ready. At that edge, register a, b, h, cin; clear idx and the result register.
- alu_* outputs are combinational from registered state:
  - alu_a = a[4*idx+:4], alu_b = b[4*idx+:4], alu_h = h.
  - alu_cin = cin when idx=0; otherwise carry_reg if arithmetic, 0 if logical.
- In IDLE/DONE, alu_a, alu_b, alu_h and alu_cin are 0.
- Each RUN edge:
  - res_f[4*idx+:4] <= alu_f.
  - carry_reg <= alu_flags[0].
  - idx increments.
  - At idx=NIB-1, capture V=alu_flags[3] and C=alu_flags[0], then go to DONE.
- Flag assembly:
  - N = res_f[WIDTH-1].
  - Z = (res_f == 0), computed locally.
  - C and V come from the last pass for arithmetic ops; forced 0 for logical ops.
- Latency: res_valid rises NIB edges after the accepting edge (2 for WIDTH=8).
- No command is accepted while RUN/DONE; upstream must hold cmd_valid.
- DONE->IDLE on res_valid&&res_ready. On that same edge, ovf_count increments if V=1, saturating at 8'hFF.
- The next command is accepted no earlier than the cycle after the result handshake (no bypass).
- While res_ready=0, res_f and res_flags hold stable indefinitely.
- Reset (async, any state, including mid-RUN):
  - state=IDLE, all registers 0, so res_f=0, res_flags=0, ovf_count=0, res_valid=0.
  - cmd_ready=1 after reset_n deasserts.
- cmd_* values are don't-care unless cmd_valid=1 in IDLE.

Test Plan:
1. WIDTH=8, a=0x0F, b=0x01, h=001, cin=0 -> res_f=0x10, res_flags=0000. res_valid exactly 2 edges after accept. alu_cin=1 during the high pass.
2. a=0x7F, b=0x01, h=001, cin=0 -> res_f=0x80, res_flags=1100, ovf_count 0->1 on the result handshake.
3. a=0x00, b=0x01, h=010, cin=1 (subtract) -> res_f=0xFF, res_flags=0100; a=0xFF, b=0x01, h=001, cin=0 -> res_f=0x00, res_flags=0011.
4. a=0x3C, b=0x0F, h=100 -> res_f=0x0C, res_flags=0000, alu_cin=0 on the high pass; h=111 with a=0xFF -> res_f=0x00, res_flags=0010.
5. Hold res_ready=0 for 5 cycles with cmd_valid=1 -> res_f/res_flags stable, cmd_ready=0, second command accepted only after the handshake.
6. Assert reset_n=0 during the first RUN cycle -> outputs immediately 0, state IDLE, ovf_count=0. After release, a new command completes correctly. Force ovf_count to saturate: 256 overflowing results -> stays 0xFF.
